// File: rtl/sc_outport_bcd_display.sv
// rtl/sc_outport_bcd_display.sv - output-port to five-digit seven-segment display
// Sequential double-dabble conversion (one bit per clock) feeding registered active-low segment drivers.
module sc_outport_bcd_display #(
  parameter int DATA_W   = 16,
  parameter int DIGITS   = 5,
  parameter int BLANK_LZ = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] port_in,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic        busy,
  output logic        valid
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_LOAD} state_t;

  state_t                  state_q, state_d;
  logic [DATA_W-1:0]       cap_q, cap_d;
  logic [DATA_W-1:0]       sh_q, sh_d;
  logic [BCD_W-1:0]        bcd_q, bcd_d;
  logic [BCD_W-1:0]        bcd_adj;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    pend_q, pend_d;
  logic                    valid_q, valid_d;
  logic [DIGITS-1:0][6:0]  hex_q, hex_d;
  logic [DATA_W-1:0]       port_lo;
  logic                    start;
  logic                    nz;
  logic [3:0]              digit;
  logic                    unused_port_hi;

  assign port_lo        = port_in[DATA_W-1:0];
  assign unused_port_hi = ^port_in[31:DATA_W];
  assign start          = pend_q || (port_lo != cap_q);

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cap_q   <= '0;
      sh_q    <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b1;
      valid_q <= 1'b0;
      hex_q   <= {DIGITS{7'h7F}};
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      hex_q   <= hex_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_CONV;
      S_CONV:  if (cnt_q == CNT_W'(1)) state_d = S_LOAD;
      S_LOAD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Add-3 correction applied before each shift so every nibble stays a valid decimal digit.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  always_comb begin
    cap_d   = cap_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    valid_d = valid_q;
    hex_d   = hex_q;
    nz      = 1'b0;
    digit   = 4'd0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cap_d  = port_lo;
          sh_d   = port_lo;
          bcd_d  = '0;
          cnt_d  = CNT_W'(DATA_W);
          pend_d = 1'b0;
        end
      end
      S_CONV: begin
        bcd_d = {bcd_adj[BCD_W-2:0], sh_q[DATA_W-1]};
        sh_d  = {sh_q[DATA_W-2:0], 1'b0};
        cnt_d = cnt_q - 1'b1;
      end
      S_LOAD: begin
        valid_d = 1'b1;
        // Walk from the most significant digit so nz marks "a nonzero digit at or above k".
        for (int k = DIGITS - 1; k >= 0; k--) begin
          digit = bcd_q[4*k +: 4];
          nz    = nz | (digit != 4'd0);
          if (BLANK_LZ != 0 && k != 0 && !nz) hex_d[k] = 7'h7F;
          else                                hex_d[k] = seg7(digit);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = (state_q == S_CONV);
  end

  assign valid = valid_q;
  assign hex0  = hex_q[0];
  assign hex1  = hex_q[1];
  assign hex2  = hex_q[2];
  assign hex3  = hex_q[3];
  assign hex4  = hex_q[4];

endmodule
